// File: rtl/line_fill_unit.sv
// Line fill unit: serialises an optional dirty-line writeback and a line read
// into single-word beats on a 32-bit backing bus, then returns the whole line.
module line_fill_unit #(
    parameter int WORDS  = 16,
    parameter int BEAT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    input  logic                  wb_valid,
    input  logic [31:0]           wb_addr,
    input  logic [WORDS*32-1:0]   wb_data,
    output logic                  fill_ready,
    output logic [WORDS*32-1:0]   fill_data,
    output logic                  busy,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rdata
);
    localparam int OFF   = BEAT_W + 2;
    localparam int TAG_W = 32 - OFF;

    typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

    state_t                 state;
    logic [BEAT_W-1:0]      beat;
    logic [BEAT_W-1:0]      beat_nxt;
    logic                   last_beat;
    logic [TAG_W-1:0]       req_line;
    logic [TAG_W-1:0]       wb_line;
    logic [WORDS-1:0][31:0] wb_words;
    logic [WORDS-1:0][31:0] fill_words;
    logic                   unused_low;

    assign beat_nxt   = beat + 1'b1;
    assign last_beat  = (beat == BEAT_W'(WORDS - 1));
    assign fill_data  = fill_words;
    assign unused_low = ^{req_addr[OFF-1:0], wb_addr[OFF-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            req_line   <= '0;
            wb_line    <= '0;
            wb_words   <= '0;
            fill_words <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            fill_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_line <= req_addr[31:OFF];
                        wb_line  <= wb_addr[31:OFF];
                        wb_words <= wb_data;
                        beat     <= '0;
                        busy     <= 1'b1;
                        state    <= wb_valid ? WB : RD;
                    end
                end
                WB: begin
                    if (!bus_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= {wb_line, beat, 2'b00};
                        bus_wdata <= wb_words[beat];
                    end else if (bus_ack) begin
                        beat <= beat_nxt;
                        // Last write beat hands straight over to the read phase; bus_req stays up.
                        if (last_beat) begin
                            state     <= RD;
                            bus_we    <= 1'b0;
                            bus_addr  <= {req_line, beat_nxt, 2'b00};
                            bus_wdata <= '0;
                        end else begin
                            bus_addr  <= {wb_line, beat_nxt, 2'b00};
                            bus_wdata <= wb_words[beat_nxt];
                        end
                    end
                end
                RD: begin
                    if (!bus_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= {req_line, beat, 2'b00};
                        bus_wdata <= '0;
                    end else if (bus_ack) begin
                        fill_words[beat] <= bus_rdata;
                        beat             <= beat_nxt;
                        if (last_beat) begin
                            state   <= DONE;
                            bus_req <= 1'b0;
                        end else begin
                            bus_addr <= {req_line, beat_nxt, 2'b00};
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle raises the pulse, second drops it and returns to IDLE.
                    if (!fill_ready) begin
                        fill_ready <= 1'b1;
                    end else begin
                        fill_ready <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_fill_unit.sv
// Directed bench for line_fill_unit: behavioural backing memory with
// programmable ack pattern, beat logger and hand-computed expected lines.
module tb_line_fill_unit;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         wb_valid;
    logic [31:0]  wb_addr;
    logic [511:0] wb_data;
    logic         fill_ready;
    logic [511:0] fill_data;
    logic         busy;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_ack;
    logic [31:0]  bus_rdata;

    int unsigned checks = 0;
    int unsigned failures = 0;

    line_fill_unit #(.WORDS(16), .BEAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .fill_ready(fill_ready), .fill_data(fill_data), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic ack_tied = 1'b0;
    logic ack_stall = 1'b0;
    assign bus_ack = ack_tied | (ack_stall & (cyc % 3 == 2));

    // Unwritten words: 0xA000_0000+i on line 0x1040, else 0x5000_0000 + word index.
    bit [31:0] mem [8192];
    bit        wr  [8192];
    function automatic logic [31:0] mem_dflt(input logic [12:0] idx);
        if (idx >= 13'h410 && idx <= 13'h41F) return 32'hA000_0000 + 32'(idx - 13'h410);
        return 32'h5000_0000 + 32'(idx);
    endfunction
    assign bus_rdata = wr[bus_addr[14:2]] ? mem[bus_addr[14:2]] : mem_dflt(bus_addr[14:2]);

    logic [31:0] log_addr  [$];
    logic        log_we    [$];
    logic [31:0] log_wdata [$];
    int unsigned log_cyc   [$];

    always @(posedge clk) begin
        if (bus_req && bus_ack) begin
            log_addr.push_back(bus_addr);
            log_we.push_back(bus_we);
            log_wdata.push_back(bus_wdata);
            log_cyc.push_back(cyc);
            if (bus_we) begin
                mem[bus_addr[14:2]] <= bus_wdata;
                wr[bus_addr[14:2]]  <= 1'b1;
            end
        end
    end

    logic        prev_hold = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    int unsigned stable_err = 0;
    always @(posedge clk) begin
        if (prev_hold && bus_req &&
            (bus_addr !== prev_addr || bus_wdata !== prev_wdata || bus_we !== prev_we))
            stable_err <= stable_err + 1;
        prev_hold  <= bus_req && !bus_ack;
        prev_addr  <= bus_addr;
        prev_wdata <= bus_wdata;
        prev_we    <= bus_we;
    end

    int unsigned ready_cnt = 0;
    always @(negedge clk) if (fill_ready) ready_cnt <= ready_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge; lat = edges from accept edge to fill_ready seen (-1 on timeout).
    task automatic run_txn(input logic wbv, input logic [31:0] ra, input logic [31:0] wa,
                           input logic [511:0] wd, input int limit, output int lat);
        req_valid = 1'b1;
        req_addr  = ra;
        wb_valid  = wbv;
        wb_addr   = wa;
        wb_data   = wd;
        lat = -1;
        @(posedge clk);
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) begin
                req_addr = ~ra;
                wb_valid = ~wbv;
                wb_addr  = ~wa;
                wb_data  = ~wd;
            end
            if (fill_ready) begin
                lat = n;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic after_ready(input string tag);
        check({tag, "_busy_at_ready"}, 512'(busy), 512'd1);
        @(posedge clk);
        #1;
        check({tag, "_ready_pulse_end"}, 512'(fill_ready), 512'd0);
        check({tag, "_idle_busy"}, 512'(busy), 512'd0);
        @(negedge clk);
    endtask

    task automatic check_beats(input string tag, input int base, input int nwb,
                               input logic [31:0] wline, input logic [31:0] rline,
                               input logic [511:0] wd);
        int err = 0;
        int total = nwb + 16;
        check({tag, "_nbeats"}, 512'(log_addr.size() - base), 512'(total));
        for (int j = 0; j < total && base + j < log_addr.size(); j++) begin
            if (j < nwb) begin
                if (log_addr[base+j] !== wline + 32'(4*j) || log_we[base+j] !== 1'b1 ||
                    log_wdata[base+j] !== wd[32*j +: 32]) err++;
            end else begin
                if (log_addr[base+j] !== rline + 32'(4*(j-nwb)) || log_we[base+j] !== 1'b0 ||
                    log_wdata[base+j] !== 32'd0) err++;
            end
        end
        check({tag, "_beat_content_errs"}, 512'(err), 512'd0);
    endtask

    initial begin
        int lat;
        int base;
        int err;
        int got;
        int unsigned rdy0;
        logic [511:0] wd;
        logic [511:0] exp_line;

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        wb_valid = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_bus_req", 512'(bus_req), 512'd0);
        check("rst_bus_we", 512'(bus_we), 512'd0);
        check("rst_fill_ready", 512'(fill_ready), 512'd0);
        check("rst_bus_addr", 512'(bus_addr), 512'd0);
        check("rst_bus_wdata", 512'(bus_wdata), 512'd0);
        check("rst_fill_data", fill_data, 512'd0);
        rst_n = 1'b1;

        // Spurious acks while idle
        ack_tied = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_ack_bus_req", 512'(bus_req), 512'd0);
        check("idle_ack_busy", 512'(busy), 512'd0);
        check("idle_ack_nbeats", 512'(log_addr.size()), 512'd0);

        // Clean miss, low address bits set, junk victim fields
        base = log_addr.size();
        rdy0 = ready_cnt;
        run_txn(1'b0, 32'h0000_1043, 32'hDEAD_BEEF, {16{32'h0BAD_0BAD}}, 60, lat);
        check("clean_latency", 512'(lat), 512'd18);
        check("clean_word5", 512'(fill_data[5*32 +: 32]), 512'h A000_0005);
        for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = 32'hA000_0000 + 32'(i);
        check("clean_line", fill_data, exp_line);
        after_ready("clean");
        check("clean_ready_count", 512'(ready_cnt - rdy0), 512'd1);
        check_beats("clean", base, 0, 32'h0, 32'h0000_1040, '0);

        // Dirty miss with ack tied high
        for (int i = 0; i < 16; i++) wd[32*i +: 32] = 32'hD0 + 32'(i);
        base = log_addr.size();
        run_txn(1'b1, 32'h0000_3000, 32'h0000_2000, wd, 80, lat);
        check("dirty_latency", 512'(lat), 512'd34);
        for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = 32'h5000_0C00 + 32'(i);
        check("dirty_line", fill_data, exp_line);
        after_ready("dirty");
        check_beats("dirty", base, 16, 32'h0000_2000, 32'h0000_3000, wd);
        err = 0;
        for (int j = 1; j < 32 && base + j < log_cyc.size(); j++)
            if (log_cyc[base+j] != log_cyc[base] + 32'(j)) err++;
        check("dirty_no_gap_errs", 512'(err), 512'd0);

        // Stalled bus: ack every third cycle
        ack_tied = 1'b0;
        ack_stall = 1'b1;
        for (int i = 0; i < 16; i++) wd[32*i +: 32] = 32'hE0 + 32'(i);
        base = log_addr.size();
        run_txn(1'b1, 32'h0000_3400, 32'h0000_2400, wd, 300, lat);
        check("stall_completed", 512'(lat > 34), 512'd1);
        for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = 32'h5000_0D00 + 32'(i);
        check("stall_line", fill_data, exp_line);
        after_ready("stall");
        check_beats("stall", base, 16, 32'h0000_2400, 32'h0000_3400, wd);
        check("stall_hold_errs", 512'(stable_err), 512'd0);
        ack_stall = 1'b0;
        ack_tied = 1'b1;

        // Writeback and read of the same line
        for (int i = 0; i < 16; i++) wd[32*i +: 32] = 32'h7700_0000 + 32'(i);
        wd[31:0] = 32'h1234_5678;
        run_txn(1'b1, 32'h0000_4000, 32'h0000_4000, wd, 80, lat);
        check("same_latency", 512'(lat), 512'd34);
        check("same_word0", 512'(fill_data[31:0]), 512'h1234_5678);
        check("same_line", fill_data, wd);
        after_ready("same");

        // Reset while the read phase is on beat 7
        base = log_addr.size();
        rdy0 = ready_cnt;
        req_valid = 1'b1;
        req_addr = 32'h0000_1040;
        wb_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (log_addr.size() - base >= 7) begin
                got = 1;
                break;
            end
        end
        check("rst_mid_reached_beat7", 512'(got), 512'd1);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_mid_bus_req", 512'(bus_req), 512'd0);
        check("rst_mid_busy", 512'(busy), 512'd0);
        check("rst_mid_fill_data", fill_data, 512'd0);
        check("rst_mid_bus_addr", 512'(bus_addr), 512'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_ready", 512'(ready_cnt - rdy0), 512'd0);
        check("rst_mid_beats", 512'(log_addr.size() - base), 512'd7);
        check("rst_mid_idle_req", 512'(bus_req), 512'd0);

        base = log_addr.size();
        run_txn(1'b0, 32'h0000_5000, 32'h0, '0, 60, lat);
        check("post_rst_latency", 512'(lat), 512'd18);
        check("post_rst_word3", 512'(fill_data[3*32 +: 32]), 512'h5000_1403);
        for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = 32'h5000_1400 + 32'(i);
        check("post_rst_line", fill_data, exp_line);
        after_ready("post_rst");
        check_beats("post_rst", base, 0, 32'h0, 32'h0000_5000, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
